pool_window_gen: RTL and testbench

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/pool_pkg.sv | 21 ++
 rtl/pool_line_buf.sv | 38 +++
 rtl/pool_window_gen.sv | 164 ++++++++++++++++
 tb/tb_pool_window_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling window generator:
// default geometry, FSM state encoding and an index-width helper.
package pool_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned IMG_W_DEF  = 8;
  localparam int unsigned IMG_H_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    DRAIN    = 2'd3
  } pool_state_e;

  // Counter width for a range of n values; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer holding the even (top) row of each 2x2 window band.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write column
//   wdata_i  - write pixel
//   raddr0_i - read column (col-1, window top-left)
//   rdata0_o - combinational read data for raddr0_i
//   raddr1_i - read column (col, window top-right)
//   rdata1_o - combinational read data for raddr1_i
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  localparam int unsigned AW    = idx_w(IMG_W)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic [AW-1:0]     raddr1_i,
  output logic [DATA_W-1:0] rdata1_o
);

  // Storage is left uninitialised; every entry is written before it is read.
  logic [DATA_W-1:0] mem_q [IMG_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a row-major pixel stream into non-overlapping 2x2 windows for a
// downstream max-pooling stage.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start              - begins a frame (sampled only in IDLE)
//   pix_in/pix_valid   - pixel stream input
//   pix_ready          - pixel accepted when pix_valid & pix_ready
//   out1..out4         - window TL/TR/BL/BR
//   win_valid/win_ready- window handshake
//   frame_done         - one-cycle pulse after the last window transfers
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_done
);

  localparam int unsigned CW = idx_w(IMG_W);
  localparam int unsigned RW = idx_w(IMG_H);

  pool_state_e       state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d, out4_q, out4_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;

  logic              pix_ready_c, pix_xfer, win_xfer, col_last, row_last;
  logic [DATA_W-1:0] top_left, top_right;

  // Accept pixels only inside a frame and only while no window is stalled.
  assign pix_ready_c = ((state_q == EVEN_ROW) || (state_q == ODD_ROW)) &&
                       !(win_valid_q && !win_ready);
  assign pix_xfer    = pix_valid && pix_ready_c;
  assign win_xfer    = win_valid_q && win_ready;
  assign col_last    = (col_q == CW'(IMG_W - 1));
  assign row_last    = (row_q == RW'(IMG_H - 1));

  pool_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_line_buf (
    .clk      (clk),
    .we_i     (pix_xfer && (state_q == EVEN_ROW)),
    .waddr_i  (col_q),
    .wdata_i  (pix_in),
    .raddr0_i (col_q - CW'(1)),
    .rdata0_o (top_left),
    .raddr1_i (col_q),
    .rdata1_o (top_right)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      held_q       <= '0;
      out1_q       <= '0;
      out2_q       <= '0;
      out3_q       <= '0;
      out4_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      held_q       <= held_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      out3_q       <= out3_d;
      out4_q       <= out4_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, counters and window assembly.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    held_d       = held_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    out3_d       = out3_q;
    out4_d       = out4_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;

    // A load below on the same edge overrides this clear.
    if (win_xfer) win_valid_d = 1'b0;

    if (pix_xfer) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EVEN_ROW;
          col_d   = '0;
          row_d   = '0;
        end
      end
      EVEN_ROW: begin
        if (pix_xfer && col_last) state_d = ODD_ROW;
      end
      ODD_ROW: begin
        if (pix_xfer) begin
          if (!col_q[0]) begin
            held_d = pix_in;
          end else begin
            out1_d      = top_left;
            out2_d      = top_right;
            out3_d      = held_q;
            out4_d      = pix_in;
            win_valid_d = 1'b1;
          end
          if (col_last) state_d = row_last ? DRAIN : EVEN_ROW;
        end
      end
      DRAIN: begin
        if (win_xfer) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_ready  = pix_ready_c;
  assign out1       = out1_q;
  assign out2       = out2_q;
  assign out3       = out3_q;
  assign out4       = out4_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen on a 4x4 frame.
module tb_pool_window_gen;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] out1, out2, out3, out4;
  logic          win_valid;
  logic          win_ready;
  logic          frame_done;

  pool_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   win;
    logic [DW-1:0] mx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;

  // Top-left pixel offset of each window in a 4x4 row-major frame.
  int tl_tab [4] = '{0, 2, 8, 10};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected windows for a frame whose pixels are base..base+15.
  task automatic push_frame(input int base);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      int   t;
      t = base + tl_tab[k];
      e.win = {DW'(t), DW'(t + 1), DW'(t + 4), DW'(t + 5)};
      e.mx  = DW'(t + 5);
      sb_q.push_back(e);
    end
  endtask

  task automatic send_pixel(input logic [DW-1:0] v);
    bit done;
    done      = 1'b0;
    pix_in    = v;
    pix_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (pix_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    if (!done) chk("pix_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_range(input int base, input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      send_pixel(DW'(base + i));
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_fd(input int exp);
    for (int n = 0; n < 100 && fd_cnt < exp; n++) @(negedge clk);
    @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt), 32'(exp));
  endtask

  // Monitor: scoreboard pops, latency and frame_done timing.
  int            pix_cnt = 0;
  int            win_cnt = 0;
  bit            fd_pend = 1'b0;
  bit            br_pend = 1'b0;
  logic [DW-1:0] br_val  = '0;

  always @(negedge clk) begin
    if (rst) begin
      pix_cnt = 0;
      win_cnt = 0;
      fd_pend = 1'b0;
      br_pend = 1'b0;
    end else begin
      if (frame_done || fd_pend) chk("frame_done_timing", 32'(frame_done), 32'(fd_pend));
      if (frame_done) fd_cnt++;
      fd_pend = 1'b0;

      if (br_pend) begin
        chk("latency_win_valid", 32'(win_valid), 32'd1);
        chk("latency_out4", 32'(out4), 32'(br_val));
        br_pend = 1'b0;
      end

      if (win_valid && win_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_window", {out1, out2, out3, out4}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          logic [DW-1:0] m;
          e = sb_q.pop_front();
          chk("window", {out1, out2, out3, out4}, e.win);
          m = out1;
          if (out2 > m) m = out2;
          if (out3 > m) m = out3;
          if (out4 > m) m = out4;
          chk("window_max", 32'(m), 32'(e.mx));
        end
        win_cnt++;
        if (win_cnt == 4) begin
          win_cnt = 0;
          fd_pend = 1'b1;
        end
      end

      if (pix_valid && pix_ready) begin
        if (((pix_cnt / 4) % 2 == 1) && (pix_cnt % 2 == 1)) begin
          br_pend = 1'b1;
          br_val  = pix_in;
        end
        pix_cnt = (pix_cnt + 1) % 16;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    win_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_outs", {out1, out2, out3, out4}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-throughput frame, pixels 0..15.
    push_frame(0);
    pulse_start();
    send_range(0, 0, 15, 1'b0);
    wait_fd(1);

    // Consumer stalls for 5 cycles after the first window.
    win_ready = 1'b0;
    push_frame(0);
    pulse_start();
    fork
      send_range(0, 0, 15, 1'b0);
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
          @(negedge clk);
          if (win_valid) seen = 1'b1;
        end
        chk("stall_first_window_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
          chk("stall_outs_stable", {out1, out2, out3, out4}, 32'h0001_0405);
          chk("stall_pix_ready", 32'(pix_ready), 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    join
    wait_fd(2);

    // Pixel stream with a bubble every other cycle.
    push_frame(0);
    pulse_start();
    send_range(0, 0, 15, 1'b1);
    wait_fd(3);

    // Reset mid-frame after pixel 9, then a fresh frame of 100..115.
    sb_q.push_back('{win: 32'h0001_0405, mx: 8'd5});
    sb_q.push_back('{win: 32'h0203_0607, mx: 8'd7});
    pulse_start();
    send_range(0, 0, 9, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_win_valid", 32'(win_valid), 32'd0);
    chk("midrst_pix_ready", 32'(pix_ready), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_outs", {out1, out2, out3, out4}, 32'd0);
    chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_frame_done", 32'(fd_cnt), 32'd3);
    @(posedge clk);
    #1;
    sb_q.push_back('{win: {8'd100, 8'd101, 8'd104, 8'd105}, mx: 8'd105});
    sb_q.push_back('{win: {8'd102, 8'd103, 8'd106, 8'd107}, mx: 8'd107});
    sb_q.push_back('{win: {8'd108, 8'd109, 8'd112, 8'd113}, mx: 8'd113});
    sb_q.push_back('{win: {8'd110, 8'd111, 8'd114, 8'd115}, mx: 8'd115});
    pulse_start();
    send_range(100, 0, 15, 1'b0);
    wait_fd(4);

    // pix_valid in IDLE is ignored; start mid-frame is ignored.
    pix_in    = 8'hAA;
    pix_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_pix_ready", 32'(pix_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    push_frame(32);
    pulse_start();
    send_range(32, 0, 5, 1'b0);
    pulse_start();
    send_range(32, 6, 15, 1'b0);
    wait_fd(5);
    @(negedge clk);
    chk("post_frame_idle_pix_ready", 32'(pix_ready), 32'd0);

    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(negedge clk);
    chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
